muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Request/response bundle between the issue logic and the iterative multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic [4:0]       rd_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [4:0]       rd_out;
  logic             wr_en;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_in,
    input  busy, done, result, rd_out, wr_en
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_in,
    output busy, done, result, rd_out, wr_en
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide: one shift-add or restoring shift-subtract step per cycle.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iterations entirely.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op;
  logic             neg;
  logic             special;
  logic [WIDTH-1:0] spec_val;
  logic [WIDTH-1:0] hi, lo, aux;
  logic [WIDTH-1:0] result_q;
  logic [4:0]       rd_q;

  logic             accept;
  logic             a_sgn, b_sgn, a_neg, b_neg;
  logic             div_zero, div_ovf, special_c, neg_c;
  logic [WIDTH-1:0] a_mag, b_mag, spec_c;

  // One iteration: hi:lo is the partial product (mul) or remainder:quotient (div).
  function automatic logic [2*WIDTH-1:0] step(input logic is_div, input logic [WIDTH-1:0] h,
                                              input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] d);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    sum     = {1'b0, h} + (l[0] ? {1'b0, d} : '0);
    shifted = {h, l[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, d};
    if (!is_div)
      return {sum, l[WIDTH-1:1]};
    else if (trial[WIDTH+1])
      return {shifted[WIDTH-1:0], l[WIDTH-2:0], 1'b0};
    else
      return {trial[WIDTH-1:0], l[WIDTH-2:0], 1'b1};
  endfunction

  // Re-apply signs to the magnitude result and pick the requested half.
  function automatic logic [WIDTH-1:0] finalize(input logic [2:0] f, input logic n,
                                                input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] l);
    logic [2*WIDTH-1:0] prod;
    prod = n ? -{h, l} : {h, l};
    if (!f[2])
      return (f[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    else if (!f[1])
      return n ? -l : l;
    else
      return n ? -h : h;
  endfunction

  assign accept = (state == IDLE) && bus.start;

  always_comb begin
    a_sgn     = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    b_sgn     = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    a_neg     = a_sgn && bus.rs1_val[WIDTH-1];
    b_neg     = b_sgn && bus.rs2_val[WIDTH-1];
    a_mag     = a_neg ? -bus.rs1_val : bus.rs1_val;
    b_mag     = b_neg ? -bus.rs2_val : bus.rs2_val;
    neg_c     = (bus.funct3[2] && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero  = bus.funct3[2] && (bus.rs2_val == '0);
    div_ovf   = ((bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) &&
                (bus.rs1_val == MOST_NEG) && (bus.rs2_val == '1);
    special_c = div_zero || div_ovf;
    spec_c    = '0;
    if (div_zero)
      spec_c = bus.funct3[1] ? bus.rs1_val : '1;
    else if (div_ovf)
      spec_c = bus.funct3[1] ? '0 : MOST_NEG;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (EarlyOut && special_c) ? DONE : CALC;
      CALC: if (cnt == LAST) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Control and write-back registers: cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else if (accept) begin
      cnt  <= '0;
      rd_q <= bus.rd_in;
      if (EarlyOut && special_c) result_q <= spec_c;
    end else if (state == CALC) begin
      if (cnt == LAST) begin
        cnt      <= '0;
        result_q <= special ? spec_val : finalize(op, neg, hi, lo);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Operand/working registers: fully reloaded on every accept, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      op       <= bus.funct3;
      neg      <= neg_c;
      special  <= special_c;
      spec_val <= spec_c;
      hi       <= '0;
      lo       <= a_mag;
      aux      <= b_mag;
    end else if (state == CALC && cnt != LAST) begin
      {hi, lo} <= step(op[2], hi, lo, aux);
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.wr_en  = (state == DONE);
  assign bus.result = result_q;
  assign bus.rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit plus hand-written busy-start and reset sequences.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic int exp_lat(input bit special);
`ifdef MULDIV_EARLY_OUT_EN
    return special ? 0 : 33;
`else
    return 33;
`endif
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.funct3  = f;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in   = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;

    vecs[0]  = '{"mul",        3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{"mulhu",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{"mulh",       3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'h0000_0000, 1'b0};
    vecs[3]  = '{"mulhsu",     3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7,  32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{"div_neg",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{"rem_neg",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{"divu",       3'b101, 32'd100,       32'd7,         5'd10, 32'd14,        1'b0};
    vecs[7]  = '{"remu",       3'b111, 32'd100,       32'd7,         5'd11, 32'd2,         1'b0};
    vecs[8]  = '{"div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1'b1};
    vecs[9]  = '{"rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 1'b1};
    vecs[10] = '{"divu_zero",  3'b101, 32'd13,        32'd0,         5'd14, 32'hFFFF_FFFF, 1'b1};
    vecs[11] = '{"remu_zero",  3'b111, 32'd13,        32'd0,         5'd15, 32'd13,        1'b1};
    vecs[12] = '{"div_zero",   3'b100, 32'hFFFF_FFF9, 32'd0,         5'd16, 32'hFFFF_FFFF, 1'b1};
    vecs[13] = '{"rem_zero",   3'b110, 32'hFFFF_FFF9, 32'd0,         5'd17, 32'hFFFF_FFF9, 1'b1};
    vecs[14] = '{"mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd18, 32'h4000_0000, 1'b0};
    vecs[15] = '{"mulhsu_min", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1'b0};
    vecs[16] = '{"div_negdv",  3'b100, 32'd7,         32'hFFFF_FFFE, 5'd20, 32'hFFFF_FFFD, 1'b0};
    vecs[17] = '{"rem_negdv",  3'b110, 32'd7,         32'hFFFF_FFFE, 5'd21, 32'h0000_0001, 1'b0};
    vecs[18] = '{"rem_bothneg",3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd22, 32'hFFFF_FFFF, 1'b0};

    bus.start   = 1'b0;
    bus.funct3  = 3'b000;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.rd_in   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   32'(bus.busy),   32'd0);
    chk("reset_done",   32'(bus.done),   32'd0);
    chk("reset_wr_en",  32'(bus.wr_en),  32'd0);
    chk("reset_result", bus.result,      32'd0);
    chk("reset_rd_out", 32'(bus.rd_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd);
      wait_done(lat);
      chk({vecs[i].name, "_latency"}, 32'(lat), 32'(exp_lat(vecs[i].special)));
      chk({vecs[i].name, "_result"}, bus.result, vecs[i].exp);
      chk({vecs[i].name, "_rd_out"}, 32'(bus.rd_out), 32'(vecs[i].rd));
      chk({vecs[i].name, "_wr_en"}, 32'(bus.wr_en), 32'd1);
      chk({vecs[i].name, "_busy"}, 32'(bus.busy), 32'd1);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_done_drop"}, 32'(bus.done), 32'd0);
      chk({vecs[i].name, "_idle"}, 32'(bus.busy), 32'd0);
      chk({vecs[i].name, "_hold"}, bus.result, vecs[i].exp);
    end

    // start held high with changing operands for the whole operation
    @(negedge clk);
    bus.start   = 1'b1;
    bus.funct3  = 3'b000;
    bus.rs1_val = 32'd7;
    bus.rs2_val = 32'hFFFF_FFFD;
    bus.rd_in   = 5'd3;
    @(posedge clk);
    lat = 0;
    #1;
    while (!bus.done && lat < 100) begin
      bus.funct3  = 3'($urandom_range(7));
      bus.rs1_val = $urandom;
      bus.rs2_val = 32'(lat);
      bus.rd_in   = 5'(lat);
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    chk("busy_start_latency", 32'(lat), 32'd33);
    chk("busy_start_result", bus.result, 32'hFFFF_FFEB);
    chk("busy_start_rd_out", 32'(bus.rd_out), 32'd3);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    chk("busy_start_no_extra_done", 32'(pulses), 32'd0);
    chk("busy_start_result_hold", bus.result, 32'hFFFF_FFEB);

    // reset in the middle of CALC
    issue(3'b101, 32'd100, 32'd7, 5'd6);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_busy",   32'(bus.busy),   32'd0);
    chk("midreset_done",   32'(bus.done),   32'd0);
    chk("midreset_wr_en",  32'(bus.wr_en),  32'd0);
    chk("midreset_result", bus.result,      32'd0);
    chk("midreset_rd_out", 32'(bus.rd_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) pulses++;
    end
    chk("midreset_no_done", 32'(pulses), 32'd0);

    // start accepted on the very first edge after reset release
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    bus.start   = 1'b1;
    bus.funct3  = 3'b101;
    bus.rs1_val = 32'd100;
    bus.rs2_val = 32'd7;
    bus.rd_in   = 5'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("post_reset_accept", 32'(bus.busy), 32'd1);
    wait_done(lat);
    chk("post_reset_latency", 32'(lat), 32'd33);
    chk("post_reset_result", bus.result, 32'd14);
    chk("post_reset_rd_out", 32'(bus.rd_out), 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
